// File: rtl/hazardctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses master; the controller uses slave.
interface hazardctrl_if #(
  parameter int CNT_W = 16
);
  logic             idexmemrd;
  logic [4:0]       idexregmuxout;
  logic [4:0]       ifidrs;
  logic [4:0]       ifidrt;
  logic             ifiduseRs;
  logic             ifiduseRt;
  logic             ifidmdop;
  logic             ifidmfhilo;
  logic             exbrtaken;
  logic             pcwr;
  logic             ifidwr;
  logic             ifidflush;
  logic             idexflush;
  logic             mdstart;
  logic             mdbusy;
  logic             mddone;
  logic [CNT_W-1:0] stallcnt;

  modport master (
    output idexmemrd, idexregmuxout, ifidrs, ifidrt, ifiduseRs, ifiduseRt,
           ifidmdop, ifidmfhilo, exbrtaken,
    input  pcwr, ifidwr, ifidflush, idexflush, mdstart, mdbusy, mddone, stallcnt
  );

  modport slave (
    input  idexmemrd, idexregmuxout, ifidrs, ifidrt, ifiduseRs, ifiduseRt,
           ifidmdop, ifidmfhilo, exbrtaken,
    output pcwr, ifidwr, ifidflush, idexflush, mdstart, mdbusy, mddone, stallcnt
  );
endinterface

// File: rtl/hazardctrl.sv
// Pipeline hazard controller: load-use bubbles, mult/div interlock with busy
// timer, taken-branch flushes, and a saturating stall-cycle counter.
module hazardctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst,
  hazardctrl_if.slave hz
);
  typedef enum logic {IDLE, MD_BUSY} state_t;

  localparam logic [7:0] MD_LAT_M1 = 8'(MD_LAT - 1);

  state_t           state_q, state_d;
  logic [7:0]       mdcnt_q, mdcnt_d;
  logic [CNT_W-1:0] stallcnt_q, stallcnt_d;

  logic luhaz, mdhaz, stall, mdstart;

  assign luhaz = hz.idexmemrd && (hz.idexregmuxout != 5'd0) &&
                 ((hz.ifiduseRs && (hz.idexregmuxout == hz.ifidrs)) ||
                  (hz.ifiduseRt && (hz.idexregmuxout == hz.ifidrt)));
  assign mdhaz = (state_q == MD_BUSY) && (hz.ifidmfhilo || hz.ifidmdop);
  assign stall = (luhaz || mdhaz) && !hz.exbrtaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mdcnt_q    <= 8'd0;
      stallcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mdcnt_q    <= mdcnt_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mdcnt_d    = mdcnt_q;
    stallcnt_d = stallcnt_q;
    case (state_q)
      IDLE: begin
        if (mdstart) begin
          state_d = MD_BUSY;
          mdcnt_d = MD_LAT_M1;
        end
      end
      MD_BUSY: begin
        if (mdcnt_q == 8'd0) state_d = IDLE;
        else                 mdcnt_d = mdcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // Saturate rather than wrap so long stalls never read as short ones.
    if (stall && (stallcnt_q != {CNT_W{1'b1}}))
      stallcnt_d = stallcnt_q + 1'b1;
  end

  always_comb begin
    hz.pcwr      = 1'b1;
    hz.ifidwr    = 1'b1;
    hz.ifidflush = 1'b0;
    hz.idexflush = 1'b0;
    mdstart      = 1'b0;
    hz.mdbusy    = 1'b0;
    hz.mddone    = 1'b0;
    if (rst) begin
      hz.pcwr      = 1'b0;
      hz.ifidwr    = 1'b0;
      hz.ifidflush = 1'b1;
      hz.idexflush = 1'b1;
    end else begin
      // Wrong-path ID instruction: flushing beats any stall.
      if (hz.exbrtaken) begin
        hz.ifidflush = 1'b1;
        hz.idexflush = 1'b1;
      end else if (stall) begin
        hz.pcwr      = 1'b0;
        hz.ifidwr    = 1'b0;
        hz.idexflush = 1'b1;
      end
      mdstart   = (state_q == IDLE) && hz.ifidmdop && !luhaz && !hz.exbrtaken;
      hz.mdbusy = (state_q == MD_BUSY);
      hz.mddone = (state_q == MD_BUSY) && (mdcnt_q == 8'd0);
    end
  end

  assign hz.mdstart  = mdstart;
  assign hz.stallcnt = stallcnt_q;
endmodule

// File: tb/tb_hazardctrl.sv
// Directed bench for hazardctrl with MD_LAT=4, CNT_W=4.
module tb_hazardctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazardctrl_if #(.CNT_W(CNT_W)) hz ();
  hazardctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

  typedef struct {
    logic       memrd;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mdop;
    logic       mfhilo;
    logic       br;
    logic       e_pcwr;
    logic       e_ifidwr;
    logic       e_ifidf;
    logic       e_idexf;
    logic       e_mdst;
    logic       e_inc;
  } vec_t;

  vec_t vecs [12];
  int total = 0;
  int passed = 0;
  int exp_cnt = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    hz.idexmemrd = 1'b0; hz.idexregmuxout = 5'd0; hz.ifidrs = 5'd0; hz.ifidrt = 5'd0;
    hz.ifiduseRs = 1'b0; hz.ifiduseRt = 1'b0; hz.ifidmdop = 1'b0; hz.ifidmfhilo = 1'b0;
    hz.exbrtaken = 1'b0;
  endtask

  task automatic set_lu();
    hz.idexmemrd = 1'b1; hz.idexregmuxout = 5'd5; hz.ifidrs = 5'd5; hz.ifiduseRs = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    //           memrd rd     rs     rt     urs   urt   mdop  mfhi  br    pcwr  ifwr  iff   idf   mdst  inc
    vecs[0]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 5'd5,  5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'd9,  5'd2,  5'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd3,  5'd4,  5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    clr_in();
    @(negedge clk);
    hz.ifidmdop = 1'b1;
    set_lu();
    #1;
    chk1("rst_pcwr", hz.pcwr, 1'b0);
    chk1("rst_ifidwr", hz.ifidwr, 1'b0);
    chk1("rst_ifidflush", hz.ifidflush, 1'b1);
    chk1("rst_idexflush", hz.idexflush, 1'b1);
    chk1("rst_mdstart", hz.mdstart, 1'b0);
    chk1("rst_mdbusy", hz.mdbusy, 1'b0);
    tick();
    chkn("rst_stallcnt", 32'(hz.stallcnt), 0);
    clr_in();
    rst = 1'b0;

    // Combinational vectors, all applied in IDLE.
    for (int i = 0; i < 12; i++) begin
      hz.idexmemrd = vecs[i].memrd; hz.idexregmuxout = vecs[i].rd;
      hz.ifidrs = vecs[i].rs; hz.ifidrt = vecs[i].rt;
      hz.ifiduseRs = vecs[i].urs; hz.ifiduseRt = vecs[i].urt;
      hz.ifidmdop = vecs[i].mdop; hz.ifidmfhilo = vecs[i].mfhilo; hz.exbrtaken = vecs[i].br;
      #1;
      chk1($sformatf("v%0d_pcwr", i), hz.pcwr, vecs[i].e_pcwr);
      chk1($sformatf("v%0d_ifidwr", i), hz.ifidwr, vecs[i].e_ifidwr);
      chk1($sformatf("v%0d_ifidflush", i), hz.ifidflush, vecs[i].e_ifidf);
      chk1($sformatf("v%0d_idexflush", i), hz.idexflush, vecs[i].e_idexf);
      chk1($sformatf("v%0d_mdstart", i), hz.mdstart, vecs[i].e_mdst);
      tick();
      if (vecs[i].e_inc) exp_cnt++;
      chkn($sformatf("v%0d_stallcnt", i), 32'(hz.stallcnt), exp_cnt);
      chk1($sformatf("v%0d_mdbusy", i), hz.mdbusy, 1'b0);
    end
    clr_in();

    // Mult/div op followed by mfhi held through the busy window.
    do_reset();
    hz.ifidmdop = 1'b1;
    #1;
    chk1("md_start", hz.mdstart, 1'b1);
    chk1("md_start_pcwr", hz.pcwr, 1'b1);
    chk1("md_start_busy", hz.mdbusy, 1'b0);
    tick();
    hz.ifidmdop = 1'b0; hz.ifidmfhilo = 1'b1;
    for (int c = 1; c <= MD_LAT; c++) begin
      #1;
      chk1($sformatf("md_c%0d_busy", c), hz.mdbusy, 1'b1);
      chk1($sformatf("md_c%0d_done", c), hz.mddone, (c == MD_LAT));
      chk1($sformatf("md_c%0d_pcwr", c), hz.pcwr, 1'b0);
      chk1($sformatf("md_c%0d_idexflush", c), hz.idexflush, 1'b1);
      tick();
    end
    #1;
    chk1("md_after_pcwr", hz.pcwr, 1'b1);
    chk1("md_after_busy", hz.mdbusy, 1'b0);
    chkn("md_after_stallcnt", 32'(hz.stallcnt), 4);

    // Back-to-back ops: second op stalls until the first IDLE cycle.
    hz.ifidmfhilo = 1'b0; hz.ifidmdop = 1'b1;
    #1;
    chk1("b2b_start1", hz.mdstart, 1'b1);
    tick();
    for (int c = 1; c <= MD_LAT; c++) begin
      #1;
      chk1($sformatf("b2b_c%0d_mdstart", c), hz.mdstart, 1'b0);
      chk1($sformatf("b2b_c%0d_pcwr", c), hz.pcwr, 1'b0);
      tick();
    end
    #1;
    chk1("b2b_start2", hz.mdstart, 1'b1);
    chkn("b2b_stallcnt", 32'(hz.stallcnt), 8);
    tick();
    hz.ifidmdop = 1'b0;

    // Reset in busy cycle 2 abandons the op.
    #1;
    chk1("rmid_c1_busy", hz.mdbusy, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk1("rmid_rst_busy", hz.mdbusy, 1'b0);
    chk1("rmid_rst_done", hz.mddone, 1'b0);
    chk1("rmid_rst_pcwr", hz.pcwr, 1'b0);
    chk1("rmid_rst_ifidflush", hz.ifidflush, 1'b1);
    tick();
    rst = 1'b0;
    for (int c = 0; c < MD_LAT; c++) begin
      #1;
      chk1($sformatf("rmid_post%0d_busy", c), hz.mdbusy, 1'b0);
      chk1($sformatf("rmid_post%0d_done", c), hz.mddone, 1'b0);
      chkn($sformatf("rmid_post%0d_stallcnt", c), 32'(hz.stallcnt), 0);
      tick();
    end

    // Saturation of the 4-bit stall counter.
    do_reset();
    set_lu();
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) chkn("sat_14", 32'(hz.stallcnt), 14);
      if (c == 15) chkn("sat_15", 32'(hz.stallcnt), 15);
    end
    #1;
    chkn("sat_20", 32'(hz.stallcnt), 15);
    chk1("sat_pcwr", hz.pcwr, 1'b0);
    clr_in();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazardctrl.md
Name: hazardctrl

Overview:
Pipeline sequencing controller that pairs with the forwarding unit. It covers the hazards that forwarding cannot resolve: load-use bubbles, interlocks on the multi-cycle multiply/divide unit, and taken-branch flushes. It drives the PC and IF/ID write enables and the IF/ID and ID/EX flush controls. It also runs the mult/div busy timer and keeps a saturating stall-cycle performance counter.

Parameters:
MD_LAT, 32, mult/div latency in cycles from mdstart to result ready in HI/LO; legal range 2..255
CNT_W, 16, width of the stall performance counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
idexmemrd  input  1  instruction in ID/EX is a load
idexregmuxout  input  5  destination register of the ID/EX instruction
ifidrs  input  5  rs field of the IF/ID instruction
ifidrt  input  5  rt field of the IF/ID instruction
ifiduseRs  input  1  IF/ID instruction reads rs
ifiduseRt  input  1  IF/ID instruction reads rt
ifidmdop  input  1  IF/ID instruction is mult/multu/div/divu
ifidmfhilo  input  1  IF/ID instruction is mfhi/mflo
exbrtaken  input  1  branch/jump resolved taken in EX this cycle
pcwr  output  1  PC write enable
ifidwr  output  1  IF/ID register write enable
ifidflush  output  1  IF/ID register loads a bubble (nop)
idexflush  output  1  ID/EX register loads a bubble
mdstart  output  1  one-cycle start pulse to the mult/div unit
mdbusy  output  1  mult/div operation in flight
mddone  output  1  one-cycle pulse on the last busy cycle
stallcnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at clock edge) sets state=IDLE, mdcnt=0, stallcnt=0. While rst is high: pcwr=0, ifidwr=0, ifidflush=1, idexflush=1, mdstart=0, mdbusy=0, mddone=0. Reset during MD_BUSY abandons the operation silently, with no mddone.
- FSM states: IDLE, MD_BUSY. The internal counter mdcnt is 8 bits.
- Load-use hazard: luhaz = idexmemrd & (idexregmuxout!=0) & ((ifiduseRs & idexregmuxout==ifidrs) | (ifiduseRt & idexregmuxout==ifidrt)).
- MD hazard: mdhaz = (state==MD_BUSY) & (ifidmfhilo | ifidmdop).
- stall = (luhaz | mdhaz) & ~exbrtaken.
- Outputs are combinational from state and inputs, with priority order:
  1. exbrtaken=1: pcwr=1, ifidwr=1, ifidflush=1, idexflush=1. Flush overrides any stall, because the ID instruction is wrong-path.
  2. stall=1: pcwr=0, ifidwr=0, ifidflush=0, idexflush=1. This is one bubble per stall cycle.
  3. Otherwise: pcwr=1, ifidwr=1, both flushes 0.
- mdstart = (state==IDLE) & ifidmdop & ~luhaz & ~exbrtaken. In other words, the op issues only in the cycle it actually advances out of ID.
- IDLE->MD_BUSY on mdstart; mdcnt loads MD_LAT-1.
- In MD_BUSY, mdcnt decrements each cycle. When mdcnt==0: mddone=1 and the next state is IDLE. mdbusy=1 for exactly MD_LAT cycles (all of MD_BUSY), and mddone asserts on the last of them.
- A second mult/div op or an mfhi/mflo stalls throughout MD_BUSY, including the mddone cycle. It advances on the first IDLE cycle. Because it advances there, a second mult/div op raises mdstart in that IDLE cycle (back-to-back ops are legal).
- exbrtaken does not cancel an in-flight mult/div; the counter continues.
- stallcnt increments by 1 on every cycle with stall=1. A simultaneous luhaz and mdhaz counts once. stallcnt saturates at all-ones and never wraps.
- A load-use hazard naturally resolves after one bubble, because the bubble clears idexmemrd. No extra state is needed.

Test Plan:
1. Load-use: idexmemrd=1, idexregmuxout=5, ifidrs=5, ifiduseRs=1 for one cycle -> that cycle pcwr=0, ifidwr=0, idexflush=1; next cycle (idexmemrd=0) all normal; stallcnt=1.
2. Load to $0 (idexregmuxout=0, ifidrs=0) -> no stall, stallcnt stays 0. Load with match on rt but ifiduseRt=0 -> no stall.
3. MD_LAT=4: ifidmdop=1 at cycle 0 -> mdstart at cycle 0; mdbusy cycles 1-4; mddone cycle 4. ifidmfhilo=1 held from cycle 1 -> stall cycles 1-4, pcwr=1 at cycle 5, stallcnt=4.
4. Taken branch during load-use: exbrtaken=1 with luhaz=1 -> pcwr=1, ifidflush=1, idexflush=1, stallcnt unchanged. With exbrtaken=1 and ifidmdop=1 in IDLE -> mdstart=0.
5. Reset mid-op: assert rst at busy cycle 2 -> next cycle mdbusy=0, mddone never pulses, stallcnt=0, outputs at reset values while rst=1.
6. Saturation with CNT_W=4: hold a stall for 20 cycles -> stallcnt reaches 15 and holds.
